// File: rtl/uart_tx_fifo.sv
// Transmit-data FIFO between the UART register decoder and the TX serializer.
// The read port is first-word-fall-through: the head byte sits on data_out while empty is low.
module uart_tx_fifo #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int AF_LEVEL = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              seltxff,
  input  logic              wr_stb,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              tx_rd,
  input  logic              flush,
  input  logic              clr_ovr,
  output logic [WIDTH-1:0]  data_out,
  output logic              empty,
  output logic              full,
  output logic              almost_ful,
  output logic [ADDR_W:0]   count,
  output logic              overrun
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_LEVEL);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overrun_q, overrun_d;

  logic we, wr_ok, rd_ok, ovr_set;

  // Handshake: a write is one cycle of seltxff & wr_stb and is taken unless the FIFO
  // is full with no pop in the same cycle; a pop is one cycle of tx_rd and is taken
  // only while not empty. Nothing is held or retried: a refused request is simply lost.
  assign we      = seltxff & wr_stb;
  assign rd_ok   = tx_rd & ~empty;
  assign wr_ok   = we & (~full | rd_ok);
  assign ovr_set = we & full & ~rd_ok & ~flush;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
    if (ovr_set)      overrun_d = 1'b1;
    else if (clr_ovr) overrun_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  // Storage carries no reset; only the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (wr_ok && !flush) mem_q[wr_ptr_q] <= data_in;
  end

  assign data_out   = mem_q[rd_ptr_q];
  assign count      = count_q;
  assign empty      = (count_q == '0);
  assign full       = (count_q == DEPTH_C);
  assign almost_ful = (count_q >= AF_C);
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a byte queue tracks expected contents, count and overrun.
module tb_uart_tx_fifo;

  logic       clk;
  logic       rst_n;
  logic       seltxff, wr_stb, tx_rd, flush, clr_ovr;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       empty, full, almost_ful, overrun;
  logic [4:0] count;

  logic [7:0] exp_q[$];
  logic       ovr_m;
  int         n_cmp;
  int         n_err;

  uart_tx_fifo #(.WIDTH(8), .DEPTH(16), .ADDR_W(4), .AF_LEVEL(12)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seltxff    (seltxff),
    .wr_stb     (wr_stb),
    .data_in    (data_in),
    .tx_rd      (tx_rd),
    .flush      (flush),
    .clr_ovr    (clr_ovr),
    .data_out   (data_out),
    .empty      (empty),
    .full       (full),
    .almost_ful (almost_ful),
    .count      (count),
    .overrun    (overrun)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag);
    check({tag, ".count"}, 32'(count), 32'(exp_q.size()));
    check({tag, ".empty"}, 32'(empty), 32'(exp_q.size() == 0));
    check({tag, ".full"},  32'(full),  32'(exp_q.size() == 16));
    check({tag, ".af"},    32'(almost_ful), 32'(exp_q.size() >= 12));
    check({tag, ".ovr"},   32'(overrun), 32'(ovr_m));
    if (exp_q.size() > 0) check({tag, ".head"}, 32'(data_out), 32'(exp_q[0]));
  endtask

  // driver: one clock of stimulus, expected-state update, then a status check
  task automatic drive(input string tag, input logic sel, input logic wr, input logic [7:0] b,
                       input logic rd, input logic fl, input logic co);
    logic full_m, rd_ok_m, wr_ok_m, set_m;
    seltxff = sel; wr_stb = wr; data_in = b; tx_rd = rd; flush = fl; clr_ovr = co;
    full_m  = (exp_q.size() == 16);
    rd_ok_m = rd && (exp_q.size() != 0);
    wr_ok_m = sel && wr && (!full_m || rd_ok_m);
    set_m   = sel && wr && full_m && !rd_ok_m && !fl;
    tick();
    seltxff = 1'b0; wr_stb = 1'b0; tx_rd = 1'b0; flush = 1'b0; clr_ovr = 1'b0;
    if (fl) begin
      exp_q.delete();
    end else begin
      if (rd_ok_m) void'(exp_q.pop_front());
      if (wr_ok_m) exp_q.push_back(b);
    end
    if (set_m)   ovr_m = 1'b1;
    else if (co) ovr_m = 1'b0;
    check_status(tag);
  endtask

  task automatic push(input logic [7:0] b);
    drive("push", 1'b1, 1'b1, b, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop();
    drive("pop", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    n_cmp = 0; n_err = 0; ovr_m = 1'b0;
    seltxff = 1'b0; wr_stb = 1'b0; tx_rd = 1'b0; flush = 1'b0; clr_ovr = 1'b0;
    data_in = 8'h00;
    rst_n = 1'b0;
    #12;
    check("rst.count", 32'(count), 32'd0);
    check("rst.empty", 32'(empty), 32'd1);
    check("rst.full",  32'(full),  32'd0);
    check("rst.af",    32'(almost_ful), 32'd0);
    check("rst.ovr",   32'(overrun), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_status("post_rst");

    // ordering
    push(8'h41); push(8'h42); push(8'h43);
    check("ord.head0", 32'(data_out), 32'h41);
    pop();
    check("ord.head1", 32'(data_out), 32'h42);
    pop();
    check("ord.head2", 32'(data_out), 32'h43);
    pop();
    check("ord.empty", 32'(empty), 32'd1);

    // fill, overrun, clear, drain
    for (int i = 0; i < 16; i++) push(8'(8'h10 + i));
    check("fill.full", 32'(full), 32'd1);
    push(8'hFF);
    check("fill.ovr", 32'(overrun), 32'd1);
    check("fill.cnt", 32'(count), 32'd16);
    drive("clr_ovr", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("clr.ovr", 32'(overrun), 32'd0);
    for (int i = 0; i < 16; i++) begin
      check("drain.data", 32'(data_out), 32'(8'h10 + i));
      pop();
    end

    // full + write + pop
    for (int i = 0; i < 16; i++) push(8'(8'hC0 + i));
    drive("full_wr_rd", 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
    check("full_wr_rd.cnt", 32'(count), 32'd16);
    check("full_wr_rd.ovr", 32'(overrun), 32'd0);
    check("full_wr_rd.head", 32'(data_out), 32'hC1);
    for (int i = 0; i < 16; i++) pop();
    // empty + write + pop
    drive("empty_wr_rd", 1'b1, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
    check("empty_wr_rd.cnt", 32'(count), 32'd1);
    check("empty_wr_rd.data", 32'(data_out), 32'h5A);
    // unselected write
    drive("unsel", 1'b0, 1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
    check("unsel.cnt", 32'(count), 32'd1);
    pop();
    // empty pop ignored
    pop();
    check("empty_pop.cnt", 32'(count), 32'd0);

    // streaming with wrap
    for (int i = 0; i < 40; i++) begin
      push(8'(8'h80 + i));
      if (exp_q.size() >= 3) pop();
    end
    while (exp_q.size() > 0) pop();

    // flush beats a write in the same cycle
    push(8'h11); push(8'h22);
    drive("flush", 1'b1, 1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
    check("flush.cnt", 32'(count), 32'd0);
    check("flush.empty", 32'(empty), 32'd1);
    push(8'h33);
    check("after_flush.data", 32'(data_out), 32'h33);
    pop();

    // asynchronous reset mid-cycle with contents and overrun set
    for (int i = 0; i < 17; i++) push(8'(i));
    check("pre_rst.ovr", 32'(overrun), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    ovr_m = 1'b0;
    check("arst.count", 32'(count), 32'd0);
    check("arst.empty", 32'(empty), 32'd1);
    check("arst.full",  32'(full),  32'd0);
    check("arst.ovr",   32'(overrun), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_status("post_arst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
